fp_mul_rr_scheduler: RTL
========================

// Module: fp_mul_rr_scheduler
// PURPOSE
//  Shares one fixed-latency FP32 multiply pipeline between N_REQ requesters.
//  - Round-robin arbitration on the request side; valid/ready on every port.
//  - A tag shift register follows each issued operation through the pipeline.
//  - Each result is steered to its requester's response FIFO.
//  - Credit counters stop any FIFO overflowing, so the multiplier is never stalled.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  MUL_LATENCY  4   cycles from mul_valid_in sampled to mul_valid_out asserted
//  RESP_DEPTH   4   entries per response FIFO; also max credits per requester
// PORTS
//  clk               in   1          clock, all logic on rising edge
//  rst               in   1          asynchronous, active-high reset
//  req_valid         in   N_REQ      requester i has an operation
//  req_ready         out  N_REQ      requester i granted this cycle (one-hot or 0)
//  req_a, req_b      in   32*N_REQ   operands, slice [32*i+:32]
//  req_rm            in   3*N_REQ    rounding mode, slice [3*i+:3]
//  mul_valid_in      out  1          issue strobe to multiplier
//  mul_in1, mul_in2  out  32         issued operands
//  mul_rounding_mode out  3          issued rounding mode
//  mul_out           in   32         multiplier result
//  mul_flags         in   4          {overflow, underflow, inexact, invalid_operation}
//  mul_valid_out     in   1          result valid
//  rsp_valid         out  N_REQ      FIFO i non-empty
//  rsp_ready         in   N_REQ      requester i pops its head
//  rsp_data          out  32*N_REQ   head result of FIFO i
//  rsp_flags         out  4*N_REQ    head flags of FIFO i
//  tag_error         out  1          sticky: result arrived with no valid tag
// BEHAVIOUR
//  Reset values
//  - On rst: all outputs 0, rr_ptr=0, credits=0, FIFOs empty, tag pipe cleared.
//  - Reset mid-operation drops all in-flight work; the multiplier shares rst.
//  Eligibility and grant
//  - eligible[i] = req_valid[i] & (credit[i] < RESP_DEPTH).
//  - Grant goes to the first eligible index searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//  - req_ready is combinational and is 1 only for the granted index.
//  - On a grant, rr_ptr <= winner+1 mod N_REQ. With no grant, rr_ptr holds.
//  Issue
//  - Issue register: on a grant the selected a, b, rm are captured.
//  - mul_valid_in=1 on the next cycle. With no grant, mul_valid_in=0 and the data holds.
//  - One issue per cycle at most.
//  Tag pipe
//  - Tag pipe of MUL_LATENCY stages carries {valid, id[$clog2(N_REQ)-1:0]}.
//  - It is loaded from the issue register each cycle, so the tag aligns with mul_valid_out.
//  Result steering
//  - On mul_valid_out, the result and flags are pushed into FIFO[tag.id].
//  - If tag.valid=0, the result is discarded and tag_error is set (cleared only by rst).
//  - If tag.valid=1 but mul_valid_out=0, the tag is dropped and tag_error is set.
//  Credits
//  - credit[i] counts ops in flight plus FIFO occupancy for requester i.
//  - +1 on grant to i; -1 on rsp_valid[i]&rsp_ready[i].
//  - Both in the same cycle: credit unchanged.
//  - Width is $clog2(RESP_DEPTH+1). Credit never exceeds RESP_DEPTH, so a FIFO push never meets a full FIFO.
//  Response FIFOs
//  - Show-ahead: rsp_data and rsp_flags show the head whenever rsp_valid=1.
//  - A push into an empty FIFO is visible the next cycle.
//  - Push and pop in the same cycle are both legal.
//  - Pointers wrap modulo RESP_DEPTH.
//  Latency
//  - Accept at cycle T -> mul_valid_in at T+1 -> mul_valid_out at T+1+MUL_LATENCY -> rsp_valid at T+2+MUL_LATENCY.
//  - With default parameters, rsp_valid rises at T+6.
//  - Throughput is 1 op/cycle when requesters keep popping.
//  - Ordering is preserved per requester. Across requesters, order follows issue order.
// TESTING
//  1. Single request: req_valid=0001, a=3F800000 (1.0), b=40000000 (2.0), rm=0 at T
//     -> req_ready[0]=1 at T; mul_valid_in at T+1; rsp_valid[0] at T+6 with data=40000000, flags=0.
//  2. All four requesters valid every cycle with rsp_ready=1111
//     -> grants 0,1,2,3,0,1,... one per cycle; each rsp_valid sees its own results, in order.
//  3. Requester 2 valid, rsp_ready[2]=0 -> exactly 4 grants to 2, then req_ready[2]=0.
//     Pop one entry -> one new grant on the next cycle.
//  4. rr_ptr=3, req_valid=1001 -> grant 3, then grant 0, then grant 3.
//     The ptr wraps and requester 0 is not starved.
//  5. Force mul_valid_out=1 with the tag pipe empty -> no FIFO push; tag_error=1 until rst.
//  6. Assert rst while 3 ops are in flight -> all outputs 0 immediately.
//     After release, no stale rsp_valid appears; the first new request completes 6 cycles after acceptance.

Source files
------------

// File: rtl/fp_mul_rr_scheduler_if.sv
// Requester, multiplier and response signals of the shared FP32 multiply scheduler.
// slave is the scheduler's view; master is the surrounding requesters plus the multiplier.
interface fp_mul_rr_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [3*N_REQ-1:0]  req_rm;
  logic                mul_valid_in;
  logic [31:0]         mul_in1;
  logic [31:0]         mul_in2;
  logic [2:0]          mul_rounding_mode;
  logic [31:0]         mul_out;
  logic [3:0]          mul_flags;
  logic                mul_valid_out;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [32*N_REQ-1:0] rsp_data;
  logic [4*N_REQ-1:0]  rsp_flags;
  logic                tag_error;

  modport slave (
    input  req_valid, req_a, req_b, req_rm, mul_out, mul_flags, mul_valid_out, rsp_ready,
    output req_ready, mul_valid_in, mul_in1, mul_in2, mul_rounding_mode,
           rsp_valid, rsp_data, rsp_flags, tag_error
  );

  modport master (
    output req_valid, req_a, req_b, req_rm, mul_out, mul_flags, mul_valid_out, rsp_ready,
    input  req_ready, mul_valid_in, mul_in1, mul_in2, mul_rounding_mode,
           rsp_valid, rsp_data, rsp_flags, tag_error
  );
endinterface

// File: rtl/fp_mul_rr_scheduler.sv
// Round-robin sharing of one fixed-latency FP32 multiplier between N_REQ requesters;
// a tag pipe steers each result into its requester's credit-protected response FIFO.
module fp_mul_rr_scheduler #(
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 4,
  parameter int RESP_DEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst,
  fp_mul_rr_scheduler_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    issue_id;
  logic             grant_any;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic [CW-1:0]    credit [N_REQ];
  logic [CW-1:0]    count  [N_REQ];
  logic [PW-1:0]    wr_ptr [N_REQ];
  logic [PW-1:0]    rd_ptr [N_REQ];
  logic [35:0]      mem    [N_REQ][RESP_DEPTH];
  logic             tag_v  [MUL_LATENCY];
  logic [IW-1:0]    tag_id [MUL_LATENCY];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Grant is suppressed during reset so every output reads 0 while rst is high.
  always_comb begin
    eligible  = '0;
    grant     = '0;
    grant_any = 1'b0;
    winner    = rr_ptr;
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = bus.req_valid[i] && (credit[i] < CW'(RESP_DEPTH));
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_any && !rst && eligible[(int'(rr_ptr) + k) % N_REQ]) begin
        grant_any = 1'b1;
        winner    = IW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
    if (grant_any) grant[winner] = 1'b1;
  end

  assign bus.req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr                <= '0;
      issue_id              <= '0;
      bus.mul_valid_in      <= 1'b0;
      bus.mul_in1           <= '0;
      bus.mul_in2           <= '0;
      bus.mul_rounding_mode <= '0;
    end else begin
      bus.mul_valid_in <= grant_any;
      if (grant_any) begin
        rr_ptr                <= (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
        issue_id              <= winner;
        bus.mul_in1           <= bus.req_a[32*int'(winner) +: 32];
        bus.mul_in2           <= bus.req_b[32*int'(winner) +: 32];
        bus.mul_rounding_mode <= bus.req_rm[3*int'(winner) +: 3];
      end
    end
  end

  // Tag pipe mirrors the multiplier depth so its last stage lines up with mul_valid_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MUL_LATENCY; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
      bus.tag_error <= 1'b0;
    end else begin
      tag_v[0]  <= bus.mul_valid_in;
      tag_id[0] <= issue_id;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      if (bus.mul_valid_out != tag_v[MUL_LATENCY-1]) bus.tag_error <= 1'b1;
    end
  end

  always_comb begin
    push          = '0;
    pop           = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.rsp_flags = '0;
    for (int i = 0; i < N_REQ; i++) begin
      push[i]          = bus.mul_valid_out && tag_v[MUL_LATENCY-1] &&
                         (tag_id[MUL_LATENCY-1] == IW'(i));
      bus.rsp_valid[i] = (count[i] != '0);
      pop[i]           = bus.rsp_valid[i] && bus.rsp_ready[i];
      if (bus.rsp_valid[i]) begin
        bus.rsp_data[32*i +: 32] = mem[i][rd_ptr[i]][35:4];
        bus.rsp_flags[4*i +: 4]  = mem[i][rd_ptr[i]][3:0];
      end
    end
  end

  // Credits cover in-flight plus queued results, so a push never meets a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        credit[i] <= '0;
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && !pop[i])      credit[i] <= credit[i] + CW'(1);
        else if (!grant[i] && pop[i]) credit[i] <= credit[i] - CW'(1);
        if (push[i] && !pop[i])       count[i]  <= count[i] + CW'(1);
        else if (!push[i] && pop[i])  count[i]  <= count[i] - CW'(1);
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= {bus.mul_out, bus.mul_flags};
  end
endmodule
